// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, completer FSM states and word type
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  typedef enum logic {S_IDLE, S_ACCESS} apb_slv_state_t;
  typedef logic [APB_DATA_W-1:0] apb_word_t;
endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: loadable down-counter that saturates at zero, done when empty
module apb_wait_ctr #(
  parameter int MAX = 0
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = MAX > 0 ? $clog2(MAX + 1) : 1;
  logic [CW-1:0] cnt;
  // load the wait budget, then count down and hold at zero
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) cnt <= '0;
    else if (load) cnt <= CW'(MAX);
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer over a bank of 32-bit registers with fixed wait states
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS    = 16,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  apb_slv_state_t state, state_d;
  apb_word_t regs [NUM_REGS];
  logic [APB_ADDR_W-3:0] idx_full;
  logic [IW-1:0] idx_q;
  logic wr_q, err_q, dec_err, setup, done;
  // range check uses the full word index so out-of-range addresses never alias
  assign idx_full = (APB_ADDR_W-2)'((PADDR - BASE_ADDR) >> 2);
  assign dec_err  = (PADDR[1:0] != 2'b0) || (PADDR < BASE_ADDR) ||
                    ({2'b0, idx_full} >= APB_ADDR_W'(NUM_REGS));
  assign setup    = state == S_IDLE && PSEL && !PENABLE;
  apb_wait_ctr #(.MAX(WAIT_CYCLES)) u_wait (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .load    (setup),
    .en      (state == S_ACCESS && PSEL && PENABLE),
    .done    (done)
  );
  // FSM state register
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= S_IDLE;
    else state <= state_d;
  // next state and response outputs; an abort or completion always returns to idle
  always_comb begin
    PREADY  = state == S_ACCESS && done && PSEL && PENABLE;
    PSLVERR = PREADY && err_q;
    PRDATA  = (PREADY && !wr_q && !err_q) ? regs[idx_q] : '0;
    state_d = state == S_IDLE ? (setup ? S_ACCESS : S_IDLE)
                              : ((!PSEL || PREADY) ? S_IDLE : S_ACCESS);
  end
  // capture the transfer attributes in SETUP; later bus changes are ignored
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      idx_q <= '0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (setup) begin
      idx_q <= idx_full[IW-1:0];
      wr_q  <= PWRITE;
      err_q <= dec_err;
    end
  // register bank: written only on a clean completing write edge
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (PREADY && wr_q && !err_q) regs[idx_q] <= PWDATA;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks across four parameterisations sharing one bus
module tb_apb_slave_regfile;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic penable = 1'b0, pwrite = 1'b0;
  logic [3:0] psel = '0;
  logic [31:0] prdata [4];
  logic [3:0] pready, pslverr;
  int checks = 0, errors = 0;
  int rc;
  logic [31:0] rd;
  logic er;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_d0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_d3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u_db (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_d2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(paddr), .PSEL(psel[3]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

  // full transfer; address and write data are disturbed in ACCESS to prove capture/sampling points
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      output int ready_cycle, output logic [31:0] r, output logic e);
    ready_cycle = 0; r = '0; e = 1'b0;
    @(posedge PCLK); #1;
    psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = ~wd;
    @(posedge PCLK); #1;
    penable = 1'b1; paddr = a + 32'h4; pwdata = wd;
    for (int n = 1; n <= 20; n++) begin
      @(negedge PCLK);
      if (pready[d]) begin
        ready_cycle = n; r = prdata[d]; e = pslverr[d];
        break;
      end
      @(posedge PCLK); #1;
    end
    if (ready_cycle != 0) begin
      @(posedge PCLK); #1;
    end
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    #12;
    checks++;
    if (pready !== 4'b0 || pslverr !== 4'b0 || prdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: pready=%b pslverr=%b prdata0=%h want 0/0/0", pready, pslverr, prdata[0]);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
  endtask

  task automatic test_basic;
    xfer(0, 32'h08, 1'b1, 32'hDEADBEEF, rc, rd, er);
    checks++;
    if (rc !== 1 || er !== 1'b0) begin
      errors++; $display("FAIL basic_write: ready_cycle=%0d err=%b want 1/0", rc, er);
    end
    xfer(0, 32'h08, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL basic_read: ready_cycle=%0d data=%h err=%b want 1/deadbeef/0", rc, rd, er);
    end
    xfer(0, 32'h0C, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL basic_read_empty: data=%h err=%b want 0/0", rd, er);
    end
  endtask

  task automatic test_wait_states;
    xfer(1, 32'h04, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 4 || rd !== 32'h0) begin
      errors++; $display("FAIL wait_read: ready_cycle=%0d data=%h want 4/0", rc, rd);
    end
    xfer(1, 32'h04, 1'b1, 32'hCAFE0001, rc, rd, er);
    xfer(1, 32'h04, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 4 || rd !== 32'hCAFE0001) begin
      errors++; $display("FAIL wait_readback: ready_cycle=%0d data=%h want 4/cafe0001", rc, rd);
    end
  endtask

  task automatic test_errors;
    xfer(0, 32'h40, 1'b1, 32'h1234, rc, rd, er);
    checks++;
    if (rc !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL err_range_write: ready_cycle=%0d err=%b want 1/1", rc, er);
    end
    xfer(0, 32'h06, 1'b1, 32'h1234, rc, rd, er);
    checks++;
    if (rc !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL err_misaligned_write: ready_cycle=%0d err=%b want 1/1", rc, er);
    end
    xfer(0, 32'h40, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++; $display("FAIL err_range_read: data=%h err=%b want 0/1", rd, er);
    end
    xfer(0, 32'h00, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL err_no_alias_reg0: data=%h err=%b want 0/0", rd, er);
    end
    xfer(0, 32'h04, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL err_no_alias_reg1: data=%h err=%b want 0/0", rd, er);
    end
    xfer(0, 32'h08, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_reg2_kept: data=%h want deadbeef", rd);
    end
  endtask

  task automatic test_base_offset;
    xfer(2, 32'h1004, 1'b1, 32'hA5A5A5A5, rc, rd, er);
    xfer(2, 32'h1004, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 1 || rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL base_readback: ready_cycle=%0d data=%h err=%b want 1/a5a5a5a5/0", rc, rd, er);
    end
    xfer(2, 32'h0FFC, 1'b1, 32'h9999, rc, rd, er);
    checks++;
    if (rc !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL base_below: ready_cycle=%0d err=%b want 1/1", rc, er);
    end
    xfer(2, 32'h103C, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL base_no_wrap_write: data=%h err=%b want 0/0", rd, er);
    end
    xfer(2, 32'h1040, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL base_above: err=%b want 1", er);
    end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    @(posedge PCLK); #1;
    psel[3] = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hFFFF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    seen = seen | pready[3];
    @(posedge PCLK); #1;
    psel[3] = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    seen = seen | pready[3];
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_ready: pready=%b want 0", seen);
    end
    xfer(3, 32'h00, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL abort_reg0: ready_cycle=%0d data=%h err=%b want 3/0/0", rc, rd, er);
    end
  endtask

  task automatic test_protocol_error;
    logic seen;
    seen = 1'b0;
    @(posedge PCLK); #1;
    psel[3] = 1'b1; penable = 1'b1; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'hAB;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      seen = seen | pready[3];
    end
    @(posedge PCLK); #1;
    psel[3] = 1'b0; penable = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL proto_no_ready: pready=%b want 0", seen);
    end
    xfer(3, 32'h00, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 3 || rd !== 32'h0) begin
      errors++; $display("FAIL proto_no_write: ready_cycle=%0d data=%h want 3/0", rc, rd);
    end
  endtask

  task automatic test_reset_mid;
    xfer(0, 32'h10, 1'b1, 32'h55, rc, rd, er);
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    checks++;
    if (pready[0] !== 1'b1 || prdata[0] !== 32'h55) begin
      errors++; $display("FAIL rstmid_pre_read: pready=%b data=%h want 1/55", pready[0], prdata[0]);
    end
    #1 PRESETn = 1'b0;
    #1;
    checks++;
    if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      errors++; $display("FAIL rstmid_read_outputs: pready=%b pslverr=%b data=%h want 0/0/0", pready[0], pslverr[0], prdata[0]);
    end
    psel[0] = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    psel[0] = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h77;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    checks++;
    if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      errors++; $display("FAIL rstmid_write_outputs: pready=%b pslverr=%b data=%h want 0/0/0", pready[0], pslverr[0], prdata[0]);
    end
    @(posedge PCLK); #1;
    psel[0] = 1'b0; penable = 1'b0;
    PRESETn = 1'b1;
    xfer(0, 32'h10, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 1 || rd !== 32'h0) begin
      errors++; $display("FAIL rstmid_reg10: ready_cycle=%0d data=%h want 1/0", rc, rd);
    end
    xfer(0, 32'h14, 1'b0, 32'h0, rc, rd, er);
    checks++;
    if (rc !== 1 || rd !== 32'h0) begin
      errors++; $display("FAIL rstmid_reg14: ready_cycle=%0d data=%h want 1/0", rc, rd);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait_states;
    test_errors;
    test_base_offset;
    test_abort;
    test_protocol_error;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB completer that sits directly downstream of the team's APB master on the same PCLK/PRESETn domain. It decodes PADDR into a bank of NUM_REGS 32-bit read/write registers. It inserts a fixed, parameterised number of wait states through PREADY, and flags bad accesses with PSLVERR. It is the default target for master bring-up and for system register storage.

Parameters:
NUM_REGS, 16, number of 32-bit registers; legal range 1..256.
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be word-aligned.
WAIT_CYCLES, 0, wait states inserted in every ACCESS phase; legal range 0..15.

Ports:
PCLK  input  1  clock; all state updates on the rising edge.
PRESETn  input  1  reset, asynchronous, active-low.
PADDR  input  32  byte address from the master.
PSEL  input  1  slave select.
PENABLE  input  1  access-phase strobe.
PWRITE  input  1  1 = write, 0 = read.
PWDATA  input  32  write data.
PRDATA  output  32  read data; valid only when PREADY=1, PWRITE=0 and PSLVERR=0.
PREADY  output  1  transfer complete.
PSLVERR  output  1  error response; qualified by PREADY.

Behaviour:
- Reset (async, PRESETn=0): FSM goes to IDLE; all registers clear to 0; wait counter clears to 0; PREADY=0, PSLVERR=0, PRDATA=0. Any in-flight transfer is dropped with no register update.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL=1 and PENABLE=0 (SETUP), capture PADDR, PWRITE and the decode error flag; load the counter with WAIT_CYCLES; next state is ACCESS.
  - IDLE: PSEL=1 with PENABLE=1 and no preceding SETUP is a protocol error. It is ignored; the block stays in IDLE and no write occurs.
  - ACCESS: while PSEL=1 and PENABLE=1, the counter decrements toward 0 each cycle. When the counter is 0, PREADY=1 and the transfer completes on that edge; next state is IDLE.
  - ACCESS: if PSEL=0 before completion, the transfer is aborted. Next state is IDLE, there is no write, and PREADY stays 0.
- Latency: PREADY rises in the (WAIT_CYCLES+1)-th ACCESS cycle. With WAIT_CYCLES=0 this is the first ACCESS cycle, so a full transfer takes 2 PCLK cycles.
- Outputs are combinational from the state, counter and captured fields:
  - PREADY = (state==ACCESS) and (cnt==0) and PSEL and PENABLE.
  - PSLVERR = PREADY and err_q.
  - PRDATA = regs[idx_q] when PREADY and !wr_q and !err_q; otherwise 32'h0.
  - In IDLE, PREADY=0 and PSLVERR=0.
- Decode:
  - offset = PADDR - BASE_ADDR, computed as a 32-bit unsigned subtraction.
  - idx = offset[31:2].
  - err = (PADDR[1:0] != 0) or (PADDR < BASE_ADDR) or (idx >= NUM_REGS).
  - idx_q is $clog2(NUM_REGS) bits wide, minimum 1. The comparison is done on the full-width idx before truncation.
- Write:
  - Occurs on the completing edge only: regs[idx_q] <= PWDATA, with PWDATA sampled on that edge and not in SETUP.
  - Errored writes are suppressed and all registers are unchanged.
- Read: the value returned is the register content in the completing cycle. There are no side effects on read.
- Back-to-back transfers: after completion the FSM always passes through IDLE. A SETUP presented in the cycle right after completion is accepted normally.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1 bit. The counter never underflows; it holds 0 until the transfer completes.
- Address or control changes during ACCESS are ignored, because the captured values are used.

Decomposition:
- Package apb_pkg holds:
  - APB_ADDR_W=32 and APB_DATA_W=32.
  - typedef enum logic {S_IDLE, S_ACCESS} apb_slv_state_t.
  - typedef logic [31:0] apb_word_t.
- One sub-module, apb_wait_ctr: loadable down-counter with ports load, en and done (done = cnt==0), parameterised by MAX. It is instantiated once for the wait-state count.
- Decode and the register bank stay inline.

Test Plan:
- Basic write/read with WAIT_CYCLES=0, NUM_REGS=16, BASE=0: write 32'hDEADBEEF to 0x08, then read 0x08. PREADY must be high in the first ACCESS cycle, PRDATA=32'hDEADBEEF, PSLVERR=0. A read of 0x0C must return 0.
- Wait states, WAIT_CYCLES=3: read 0x04. PREADY must be 0 for 3 ACCESS cycles and 1 on the 4th. The master must stay in ACCESS until then.
- Errors: write 32'h1234 to 0x40 (idx 16, out of range) and to 0x06 (misaligned). Each must give PREADY=1 with PSLVERR=1 and leave all registers unchanged. A read of 0x40 must return PRDATA=0 with PSLVERR=1.
- Base offset, BASE=32'h1000: write 32'hA5A5A5A5 to 0x1004, then read 0x1004 and get the same value back. An access to 0x0FFC must give PSLVERR=1.
- Abort and protocol error, WAIT_CYCLES=2:
  - Drop PSEL in the 2nd ACCESS cycle of a write of 32'hFFFF to 0x00. reg0 must stay 0, the FSM must return to IDLE, and a following normal read of 0x00 must return 0.
  - PENABLE=1 with PSEL=1 and no SETUP must produce no PREADY.
- Reset mid-operation: after writing 32'h55 to 0x10, start a write of 32'h77 to 0x14 and assert PRESETn=0 during ACCESS. PREADY, PSLVERR and PRDATA must go to 0 immediately. After release, reads of 0x10 and 0x14 must both return 0.
